// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// Control word layout, state and opcode-class encodings, ALU/branch helpers.
package cpu_ctrl_pkg;

  localparam int CW_W   = 31;
  localparam int K_W    = 64;
  localparam int INSN_W = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EX0   = 2'b01,
    S_EX1   = 2'b10,
    S_EX2   = 2'b11
  } state_e;

  typedef enum logic [3:0] {
    C_B, C_CBZ, C_CBNZ, C_BCOND,
    C_RALU, C_IALU, C_LDUR, C_STUR, C_ILL
  } class_e;

  localparam logic [1:0] PSEL_HOLD = 2'b00;
  localparam logic [1:0] PSEL_PC4  = 2'b01;
  localparam logic [1:0] PSEL_A    = 2'b10;
  localparam logic [1:0] PSEL_K    = 2'b11;

  localparam logic [4:0] F_AND   = 5'd0;
  localparam logic [4:0] F_ORR   = 5'd1;
  localparam logic [4:0] F_ADD   = 5'd2;
  localparam logic [4:0] F_EOR   = 5'd3;
  localparam logic [4:0] F_SUB   = 5'd6;
  localparam logic [4:0] F_PASSB = 5'd7;

  localparam logic [4:0] REG_NONE = 5'h1F;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'hB4;
  localparam logic [7:0]  OP_CBNZ  = 8'hB5;
  localparam logic [7:0]  OP_BCOND = 8'h54;
  localparam logic [10:0] OP_LDUR  = 11'h7C2;
  localparam logic [10:0] OP_STUR  = 11'h7C0;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_ADDS = 11'h558;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_SUBS = 11'h758;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_EOR  = 11'h650;

  localparam logic [9:0] OP_ADDI  = 10'h244;
  localparam logic [9:0] OP_ADDIS = 10'h2C4;
  localparam logic [9:0] OP_SUBI  = 10'h344;
  localparam logic [9:0] OP_SUBIS = 10'h3C4;
  localparam logic [9:0] OP_ANDI  = 10'h248;
  localparam logic [9:0] OP_ORRI  = 10'h2C8;
  localparam logic [9:0] OP_EORI  = 10'h348;

  typedef struct packed {
    logic [1:0] psel;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] fsel;
    logic       regw;
    logic       ramw;
    logic       en_mem;
    logic       en_alu;
    logic       en_b;
    logic       en_pc;
    logic       bsel;
    logic       pcsel;
    logic       sl;
  } cw_t;

  localparam cw_t FETCH_CW =
    {PSEL_PC4, REG_NONE, REG_NONE, REG_NONE, F_AND, 9'h0};
  localparam cw_t NOP_CW =
    {PSEL_HOLD, REG_NONE, REG_NONE, REG_NONE, F_AND, 9'h0};

  // arith = IR[24] splits add/sub from logical in both R and I forms
  function automatic logic [4:0] alu_fsel(
    input logic       arith,
    input logic [1:0] opc
  );
    logic [4:0] f;
    if (arith) begin
      f = opc[1] ? F_SUB : F_ADD;
    end else begin
      unique case (opc)
        2'b00:   f = F_AND;
        2'b01:   f = F_ORR;
        default: f = F_EOR;
      endcase
    end
    return f;
  endfunction

  // flags = {V,C,N,Z}; odd codes invert the even test except AL/NV
  function automatic logic cond_taken(
    input logic [3:0] cond,
    input logic [3:0] flags
  );
    logic v, c, n, z, base;
    v = flags[3];
    c = flags[2];
    n = flags[1];
    z = flags[0];
    unique case (cond[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    if (cond[0] && (cond != 4'hF)) base = ~base;
    return base;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction-memory / datapath side bundle of the control sequencer.
// slave = sequencer, master = environment driving fetch data and flags.
interface control_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic [INSN_W-1:0] instruction_in;
  logic [3:0]        status;
  logic              alu_zero;
  logic [CW_W-1:0]   controlword;
  logic [K_W-1:0]    K;
  logic [1:0]        state;
  logic [INSN_W-1:0] ir;
  logic              illegal;

  modport slave (
    input  instruction_in, status, alu_zero,
    output controlword, K, state, ir, illegal
  );

  modport master (
    output instruction_in, status, alu_zero,
    input  controlword, K, state, ir, illegal
  );
endinterface

// File: rtl/insn_class_decode.sv
// Opcode classifier: IR[31:21] -> instruction class.
// Pure combinational; anything not recognised maps to C_ILL.
module insn_class_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [10:0] op_i,
  output class_e      cls_o
);

  // Priority-free match: every opcode pattern is disjoint
  always_comb begin
    cls_o = C_ILL;
    unique case (1'b1)
      (op_i[10:5] == OP_B):     cls_o = C_B;
      (op_i[10:3] == OP_CBZ):   cls_o = C_CBZ;
      (op_i[10:3] == OP_CBNZ):  cls_o = C_CBNZ;
      (op_i[10:3] == OP_BCOND): cls_o = C_BCOND;
      (op_i == OP_LDUR):        cls_o = C_LDUR;
      (op_i == OP_STUR):        cls_o = C_STUR;
      (op_i inside {OP_ADD, OP_ADDS, OP_SUB, OP_SUBS,
                    OP_AND, OP_ORR, OP_EOR}):
        cls_o = C_RALU;
      (op_i[10:1] inside {OP_ADDI, OP_ADDIS, OP_SUBI,
                          OP_SUBIS, OP_ANDI, OP_ORRI,
                          OP_EORI}):
        cls_o = C_IALU;
      default: cls_o = C_ILL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control front end: IR + state flops, per-class control word.
// Build option ILLEGAL_TRAP_EN: unknown opcodes trap in EX0 until reset.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input logic                clock,
  input logic                reset_n,
  control_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [INSN_W-1:0] ir_q, ir_d;
  class_e            cls;
  cw_t               cw;
  logic [K_W-1:0]    k;
  logic              ill;

  logic [4:0] rd, rn, rm;
  assign rd = ir_q[4:0];
  assign rn = ir_q[9:5];
  assign rm = ir_q[20:16];

  insn_class_decode u_dec (
    .op_i  (ir_q[31:21]),
    .cls_o (cls)
  );

  // State and IR are the only storage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next state, control word and K from (state, IR, flags)
  always_comb begin
    state_d = S_FETCH;
    ir_d    = ir_q;
    cw      = NOP_CW;
    k       = '0;
    ill     = 1'b0;
    if (state_q == S_FETCH) begin
      cw      = FETCH_CW;
      ir_d    = bus.instruction_in;
      state_d = S_EX0;
    end else begin
      unique case (cls)
        C_B: if (state_q == S_EX0) begin
          cw.psel   = PSEL_K;
          cw.pcsel  = 1'b1;
          cw.en_alu = 1'b1;
          k = {38'b0, ir_q[25:0]};
        end
        C_CBZ, C_CBNZ: if (state_q == S_EX0) begin
          cw.sb    = rd;
          cw.fsel  = F_PASSB;
          cw.pcsel = 1'b1;
          cw.psel  = (bus.alu_zero == (cls == C_CBZ))
                   ? PSEL_K : PSEL_HOLD;
          k = {45'b0, ir_q[23:5]};
        end
        C_BCOND: if (state_q == S_EX0) begin
          cw.pcsel = 1'b1;
          cw.psel  = cond_taken(ir_q[3:0], bus.status)
                   ? PSEL_K : PSEL_HOLD;
          k = {45'b0, ir_q[23:5]};
        end
        C_RALU, C_IALU: if (state_q == S_EX0) begin
          cw.da     = rd;
          cw.sa     = rn;
          cw.fsel   = alu_fsel(ir_q[24], ir_q[30:29]);
          cw.regw   = 1'b1;
          cw.en_alu = 1'b1;
          cw.sl     = ir_q[24] & ir_q[29];
          if (cls == C_RALU) begin
            cw.sb = rm;
          end else begin
            cw.bsel = 1'b1;
            k = {52'b0, ir_q[21:10]};
          end
        end
        C_LDUR, C_STUR:
          if (state_q inside {S_EX0, S_EX1}) begin
            // address Rn+K stays on the ALU for both cycles
            cw.sa   = rn;
            cw.bsel = 1'b1;
            cw.fsel = F_ADD;
            k = {55'b0, ir_q[20:12]};
            if (state_q == S_EX0) begin
              cw.en_alu = 1'b1;
              state_d   = S_EX1;
            end else if (cls == C_LDUR) begin
              cw.da     = rd;
              cw.en_mem = 1'b1;
              cw.regw   = 1'b1;
            end else begin
              cw.sb   = rd;
              cw.ramw = 1'b1;
              cw.en_b = 1'b1;
            end
          end
        C_ILL: if (state_q == S_EX0) begin
`ifdef ILLEGAL_TRAP_EN
          ill     = 1'b1;
          state_d = S_EX0;
`else
          ill     = 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.controlword = cw;
  assign bus.K           = k;
  assign bus.state       = state_q;
  assign bus.ir          = ir_q;
  assign bus.illegal     = ill;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: vector table plus
// multi-cycle LDUR/STUR, illegal-opcode and async-reset sequences.
module tb_control_sequencer;

  logic clock = 1'b0;
  logic reset_n;

  control_sequencer_if bus ();

  control_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] N = 5'h1F;
  localparam logic [30:0] FCW =
    {2'b01, 5'h1F, 5'h1F, 5'h1F, 5'h00, 9'h000};
  localparam logic [30:0] NCW =
    {2'b00, 5'h1F, 5'h1F, 5'h1F, 5'h00, 9'h000};

  typedef struct {
    logic [31:0] insn;
    logic        z;
    logic [3:0]  st;
    logic [30:0] cw;
    logic [63:0] k;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [30:0] mk(
    input logic [1:0] p,
    input logic [4:0] da,
    input logic [4:0] sa,
    input logic [4:0] sb,
    input logic [4:0] f,
    input logic [8:0] fl
  );
    return {p, da, sa, sb, f, fl};
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tbl[0]  = '{32'h14000010, 1'b0, 4'h0,
                mk(3, N, N, N, 0, 9'b000100010), 64'h10};
    tbl[1]  = '{32'hB4000043, 1'b1, 4'h0,
                mk(3, N, N, 3, 7, 9'b000000010), 64'h2};
    tbl[2]  = '{32'hB4000043, 1'b0, 4'h0,
                mk(0, N, N, 3, 7, 9'b000000010), 64'h2};
    tbl[3]  = '{32'hB5000043, 1'b0, 4'h0,
                mk(3, N, N, 3, 7, 9'b000000010), 64'h2};
    tbl[4]  = '{32'hB5000043, 1'b1, 4'h0,
                mk(0, N, N, 3, 7, 9'b000000010), 64'h2};
    tbl[5]  = '{32'h54000040, 1'b0, 4'b0001,
                mk(3, N, N, N, 0, 9'b000000010), 64'h2};
    tbl[6]  = '{32'h54000040, 1'b0, 4'b0000,
                mk(0, N, N, N, 0, 9'b000000010), 64'h2};
    tbl[7]  = '{32'h5400004A, 1'b0, 4'b1010,
                mk(3, N, N, N, 0, 9'b000000010), 64'h2};
    tbl[8]  = '{32'h5400004B, 1'b0, 4'b1010,
                mk(0, N, N, N, 0, 9'b000000010), 64'h2};
    tbl[9]  = '{32'hAB030041, 1'b0, 4'h0,
                mk(0, 1, 2, 3, 2, 9'b100100001), 64'h0};
    tbl[10] = '{32'hCB0600A4, 1'b0, 4'h0,
                mk(0, 4, 5, 6, 6, 9'b100100000), 64'h0};
    tbl[11] = '{32'hCA090107, 1'b0, 4'h0,
                mk(0, 7, 8, 9, 3, 9'b100100000), 64'h0};
    tbl[12] = '{32'h91001441, 1'b0, 4'h0,
                mk(0, 1, 2, N, 2, 9'b100100100), 64'h5};
    tbl[13] = '{32'hB203FC62, 1'b0, 4'h0,
                mk(0, 2, 3, N, 1, 9'b100100100), 64'hFF};
    tbl[14] = '{32'h5400004E, 1'b0, 4'h0,
                mk(3, N, N, N, 0, 9'b000000010), 64'h2};

    reset_n            = 1'b0;
    bus.instruction_in = '0;
    bus.status         = '0;
    bus.alu_zero       = 1'b0;
    #12;
    chk("rst_state", 64'(bus.state), 64'h0);
    chk("rst_ir", 64'(bus.ir), 64'h0);
    chk("rst_cw", 64'(bus.controlword), 64'(FCW));
    chk("rst_k", bus.K, 64'h0);
    chk("rst_ill", 64'(bus.illegal), 64'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      chk($sformatf("v%0d_fetch_st", i), 64'(bus.state), 64'h0);
      chk($sformatf("v%0d_fetch_cw", i),
          64'(bus.controlword), 64'(FCW));
      bus.instruction_in = tbl[i].insn;
      bus.alu_zero       = tbl[i].z;
      bus.status         = tbl[i].st;
      step();
      chk($sformatf("v%0d_ex_st", i), 64'(bus.state), 64'h1);
      chk($sformatf("v%0d_ir", i), 64'(bus.ir), 64'(tbl[i].insn));
      chk($sformatf("v%0d_cw", i),
          64'(bus.controlword), 64'(tbl[i].cw));
      chk($sformatf("v%0d_k", i), bus.K, tbl[i].k);
      chk($sformatf("v%0d_ill", i), 64'(bus.illegal), 64'h0);
      step();
      chk($sformatf("v%0d_next", i), 64'(bus.state), 64'h0);
    end

    // LDUR X5,[X6,#8]: address cycle then load-writeback cycle
    bus.instruction_in = 32'hF84080C5;
    step();
    chk("ldur_ex0_st", 64'(bus.state), 64'h1);
    chk("ldur_ex0_cw", 64'(bus.controlword),
        64'(mk(0, N, 6, N, 2, 9'b000100100)));
    chk("ldur_ex0_k", bus.K, 64'h8);
    step();
    chk("ldur_ex1_st", 64'(bus.state), 64'h2);
    chk("ldur_ex1_cw", 64'(bus.controlword),
        64'(mk(0, 5, 6, N, 2, 9'b101000100)));
    chk("ldur_ex1_k", bus.K, 64'h8);
    step();
    chk("ldur_done", 64'(bus.state), 64'h0);

    // STUR X5,[X6,#8]
    bus.instruction_in = 32'hF80080C5;
    step();
    chk("stur_ex0_cw", 64'(bus.controlword),
        64'(mk(0, N, 6, N, 2, 9'b000100100)));
    step();
    chk("stur_ex1_st", 64'(bus.state), 64'h2);
    chk("stur_ex1_cw", 64'(bus.controlword),
        64'(mk(0, N, 6, 5, 2, 9'b010010100)));
    step();
    chk("stur_done", 64'(bus.state), 64'h0);

    // Unrecognised opcode 0x00000000
    bus.instruction_in = 32'h0;
    step();
    chk("ill_st", 64'(bus.state), 64'h1);
    chk("ill_cw", 64'(bus.controlword), 64'(NCW));
`ifdef ILLEGAL_TRAP_EN
    chk("ill_flag", 64'(bus.illegal), 64'h1);
    step();
    chk("ill_hold", 64'(bus.state), 64'h1);
    chk("ill_hold_flag", 64'(bus.illegal), 64'h1);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
`else
    chk("ill_flag", 64'(bus.illegal), 64'h0);
    step();
    chk("ill_next", 64'(bus.state), 64'h0);
`endif

    // Async reset in EX1 of LDUR
    bus.instruction_in = 32'hF84080C5;
    step();
    step();
    chk("mid_ex1", 64'(bus.state), 64'h2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_st", 64'(bus.state), 64'h0);
    chk("mid_rst_ir", 64'(bus.ir), 64'h0);
    chk("mid_rst_cw", 64'(bus.controlword), 64'(FCW));
    chk("mid_rst_k", bus.K, 64'h0);
    #2;
    reset_n = 1'b1;
    bus.instruction_in = 32'h14000010;
    step();
    chk("post_rst_st", 64'(bus.state), 64'h1);
    chk("post_rst_k", bus.K, 64'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
